// File: rtl/alu_sequencer.sv
// Command sequencer around an external combinational 8-bit ALU with a 4x8 register file.
// Multiplies are done by repeated addition through the same ALU.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs,
    input  logic [1:0] cmd_rt,
    input  logic       cmd_use_imm,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends combinationally on ready in this block.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      rd_q, rd_d;
    logic [7:0]      opa_q, opa_d;
    logic [7:0]      opb_q, opb_d;
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            cy_q, cy_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic [3:0][7:0] regs_q, regs_d;
    logic [7:0]      opb_in;

    assign opb_in = cmd_use_imm ? cmd_imm : regs_q[cmd_rt];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        regs_d      = regs_q;
        alu_a       = 8'd0;
        alu_b       = 8'd0;
        alu_opcode  = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    opa_d   = regs_q[cmd_rs];
                    opb_d   = opb_in;
                    acc_d   = 8'd0;
                    cnt_d   = opb_in;
                    cy_d    = 1'b0;
                    state_d = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LDI) begin
                    regs_d[rd_q] = opb_q;
                    rsp_data_d   = opb_q;
                    rsp_flags_d  = {1'b0, opb_q[7], 1'b0, opb_q == 8'd0};
                end else begin
                    alu_a        = opa_q;
                    alu_b        = opb_q;
                    alu_opcode   = op_q;
                    regs_d[rd_q] = alu_result;
                    rsp_data_d   = alu_result;
                    rsp_flags_d  = alu_flags;
                end
                state_d = S_RESP;
            end
            S_MUL: begin
                // cnt counts remaining additions of opA into acc; carry is sticky across them.
                if (cnt_q != 8'd0) begin
                    alu_a      = acc_q;
                    alu_b      = opa_q;
                    alu_opcode = OP_ADD;
                    acc_d      = alu_result;
                    cnt_d      = cnt_q - 8'd1;
                    cy_d       = cy_q | alu_flags[1];
                end else begin
                    regs_d[rd_q] = acc_q;
                    rsp_data_d   = acc_q;
                    rsp_flags_d  = {1'b0, acc_q[7], cy_q, acc_q == 8'd0};
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            rd_q        <= 2'd0;
            opa_q       <= 8'd0;
            opb_q       <= 8'd0;
            acc_q       <= 8'd0;
            cnt_q       <= 8'd0;
            cy_q        <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_flags_q <= 4'd0;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            regs_q      <= regs_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and reference model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs, cmd_rt;
    logic       cmd_use_imm;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_regs [4];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .busy(busy), .dbg_state(dbg_state)
    );

    // External ALU: returns {V, N, C, Z, result}.
    function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c, v;
        w = 9'd0; p = 16'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            3'd6: begin p = a * b; r = p[7:0]; end
            default: r = b;
        endcase
        return {v, r[7], c, r == 8'd0, r};
    endfunction

    always_comb begin
        {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);
    end

    // Architectural result of a command: MUL is the true product, carry set if it overflows 8 bits.
    function automatic logic [11:0] model_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int         p;
        logic [7:0] r;
        if (op == 3'd6) begin
            p = int'(a) * int'(b);
            r = p[7:0];
            return {1'b0, r[7], p > 255, r == 8'd0, r};
        end else if (op == 3'd7) begin
            return {1'b0, b[7], 1'b0, b == 8'd0, b};
        end
        return alu_fn(op, a, b);
    endfunction

    task automatic drive_junk(input bit en);
        cmd_valid   = en ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_op      = 3'($urandom);
        cmd_rd      = 2'($urandom);
        cmd_rs      = 2'($urandom);
        cmd_rt      = 2'($urandom);
        cmd_use_imm = 1'($urandom);
        cmd_imm     = 8'($urandom);
    endtask

    // Called right after a negedge; returns just after the acceptance edge.
    task automatic start_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [1:0] rt, input logic use_imm, input logic [7:0] imm);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_use_imm = use_imm; cmd_imm = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [1:0] rt, input logic use_imm, input logic [7:0] imm,
                          input int hold, input bit junk,
                          output logic [7:0] got_data, output logic [3:0] got_flags, output int got_lat);
        logic [7:0]  a, b;
        logic [11:0] exp;
        int          exp_lat, lat;
        a = m_regs[rs];
        b = use_imm ? imm : m_regs[rt];
        exp = model_fn(op, a, b);
        exp_lat = (op == 3'd6) ? int'(b) + 2 : 2;
        start_cmd(op, rd, rs, rt, use_imm, imm);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && op != 3'd6) begin
                checks++;
                if (op == 3'd7 && {alu_a, alu_b, alu_opcode} !== 19'd0) begin
                    errors++;
                    $display("FAIL ldi_alu_idle alu=%h/%h/%0d want 0", alu_a, alu_b, alu_opcode);
                end else if (op != 3'd7 && {alu_a, alu_b, alu_opcode} !== {a, b, op}) begin
                    errors++;
                    $display("FAIL exec_alu_drive alu=%h/%h/%0d want %h/%h/%0d", alu_a, alu_b, alu_opcode, a, b, op);
                end
            end
            drive_junk(junk);
        end while (rsp_valid !== 1'b1 && lat < 400);
        got_data = rsp_data; got_flags = rsp_flags; got_lat = lat;
        checks++;
        if (rsp_valid !== 1'b1 || lat != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0d got %0d want %0d", op, lat, exp_lat);
        end
        checks++;
        if (rsp_data !== exp[7:0] || rsp_flags !== exp[11:8]) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h got %h/%b want %h/%b", op, a, b, rsp_data, rsp_flags, exp[7:0], exp[11:8]);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resp_status cmd_ready=%b busy=%b want 0/1", cmd_ready, busy);
        end
        m_regs[rd] = exp[7:0];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive_junk(junk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== got_data || rsp_flags !== got_flags || cmd_ready !== 1'b0
                || {alu_a, alu_b, alu_opcode} !== 19'd0) begin
                errors++;
                $display("FAIL resp_hold v=%b d=%h f=%b rdy=%b alu=%h/%h want 1/%h/%b/0/0",
                         rsp_valid, rsp_data, rsp_flags, cmd_ready, alu_a, alu_b, got_data, got_flags);
            end
        end
        rsp_ready = 1'b1;
        drive_junk(junk);
        if (junk) cmd_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL resp_done cmd_ready=%b rsp_valid=%b busy=%b want 1/0/0", cmd_ready, rsp_valid, busy);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'd0 || rsp_flags !== 4'd0
            || {alu_a, alu_b, alu_opcode} !== 19'd0) begin
            errors++;
            $display("FAIL reset rdy=%b v=%b busy=%b d=%h f=%b alu=%h/%h/%0d want 1/0/0/00/0000/0",
                     cmd_ready, rsp_valid, busy, rsp_data, rsp_flags, alu_a, alu_b, alu_opcode);
        end
    endtask

    task automatic test_directed;
        logic [7:0] d; logic [3:0] f; int l;
        do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 0, 1'b0, d, f, l);
        do_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, 0, 1'b0, d, f, l);
        do_cmd(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 0, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h80 || f !== 4'b1100 || l != 2) begin
            errors++; $display("FAIL add_overflow got %h/%b/%0d want 80/1100/2", d, f, l);
        end
        do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 0, 1'b0, d, f, l);
        do_cmd(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'hFF, 1, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h00 || f !== 4'b0011) begin
            errors++; $display("FAIL add_carry got %h/%b want 00/0011", d, f);
        end
        do_cmd(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 0, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL raw_same_reg got %h want 00", d);
        end
        do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0, 1'b0, d, f, l);
        do_cmd(3'd6, 2'd2, 2'd1, 2'd0, 1'b1, 8'h07, 0, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h23 || f !== 4'b0000 || l != 9) begin
            errors++; $display("FAIL mul_5x7 got %h/%b/%0d want 23/0000/9", d, f, l);
        end
        do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10, 0, 1'b0, d, f, l);
        do_cmd(3'd6, 2'd2, 2'd1, 2'd0, 1'b1, 8'h10, 0, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h00 || f !== 4'b0011 || l != 18) begin
            errors++; $display("FAIL mul_wrap got %h/%b/%0d want 00/0011/18", d, f, l);
        end
        do_cmd(3'd6, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 0, 1'b0, d, f, l);
        checks++;
        if (d !== 8'h00 || f !== 4'b0001 || l != 2) begin
            errors++; $display("FAIL mul_zero got %h/%b/%0d want 00/0001/2", d, f, l);
        end
    endtask

    task automatic test_resp_hold;
        logic [7:0] d; logic [3:0] f; int l;
        do_cmd(3'd4, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 5, 1'b1, d, f, l);
        do_cmd(3'd1, 2'd3, 2'd3, 2'd0, 1'b1, 8'h91, 5, 1'b1, d, f, l);
    endtask

    task automatic test_reset_abort;
        logic [7:0] d; logic [3:0] f; int l;
        for (int i = 0; i < 4; i++)
            do_cmd(3'd7, 2'(i), 2'd0, 2'd0, 1'b1, 8'(8'h5A + i), 0, 1'b0, d, f, l);
        start_cmd(3'd6, 2'd0, 2'd1, 2'd0, 1'b1, 8'd20);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_status rdy=%b v=%b busy=%b want 1/0/0", cmd_ready, rsp_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(3'd0, 2'(i), 2'(i), 2'd0, 1'b1, 8'h00, 0, 1'b0, d, f, l);
            checks++;
            if (d !== 8'h00) begin
                errors++; $display("FAIL abort_reg%0d got %h want 00", i, d);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d; logic [3:0] f; int l;
        logic [2:0] op;
        logic [7:0] imm;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom);
            imm = (op == 3'd6) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            do_cmd(op, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), imm,
                   $urandom_range(0, 3), 1'($urandom), d, f, l);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d; logic [3:0] f; int l;
        do_cmd(3'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'hC3, 0, 1'b1, d, f, l);
        do_cmd(3'd6, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 0, 1'b1, d, f, l);
        do_cmd(3'd5, 2'd1, 2'd2, 2'd0, 1'b1, 8'h10, 0, 1'b1, d, f, l);
        do_cmd(3'd3, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 0, 1'b1, d, f, l);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        drive_junk(1'b0);
        @(negedge clk);
        test_reset;
        test_directed;
        test_resp_hold;
        test_back_to_back;
        test_random;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
